// File: rtl/mult_div_pkg.sv
// Shared op encodings and FSM state codes for the
// iterative multiply/divide engine and its control FSM.
package mult_div_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef logic [1:0] stateT;

   localparam stateT IDLE = 2'd0;
   localparam stateT CALC = 2'd1;
   localparam stateT FIX  = 2'd2;

endpackage

// File: rtl/mult_div_seq.sv
// Shared shift-add multiplier / restoring divider, one bit per cycle,
// with start/busy/done handshake, abort and divide-by-zero flag.
module mult_div_seq
   import mult_div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNTW = $clog2(WIDTH) + 1;
   localparam logic [CNTW-1:0] LASTCNT = CNTW'(WIDTH - 1);

   stateT            state;
   logic [CNTW-1:0]  count;
   logic             opDiv;
   logic             qSign;
   logic             rSign;
   logic             zeroFlag;
   logic [WIDTH:0]   accHi;
   logic [WIDTH-1:0] accLo;
   logic [WIDTH-1:0] opB;

   logic             signedOp;
   logic             divOp;
   logic             aNeg;
   logic             bNeg;
   logic [WIDTH-1:0] aMag;
   logic [WIDTH-1:0] bMag;
   logic             accept;
   logic             bZero;

   assign signedOp = (op == OP_MULT) || (op == OP_DIV);
   assign divOp    = (op == OP_DIV) || (op == OP_DIVU);
   assign aNeg     = signedOp & a[WIDTH-1];
   assign bNeg     = signedOp & b[WIDTH-1];
   assign aMag     = aNeg ? -a : a;
   assign bMag     = bNeg ? -b : b;
   assign bZero    = (b == '0);
   assign accept   = (state == IDLE) && start && !abort;

   // Multiply: accLo holds the remaining multiplier bits, accHi the running sum
   logic [WIDTH:0] addend;
   logic [WIDTH:0] mulSum;

   assign addend = accLo[0] ? {1'b0, opB} : '0;
   assign mulSum = accHi + addend;

   // Divide: accHi is the partial remainder, accLo shifts dividend out / quotient in
   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] diff;
   logic             fits;

   assign shifted = {accHi[WIDTH-1:0], accLo[WIDTH-1]};
   assign diff    = {1'b0, shifted} - {2'b00, opB};
   assign fits    = !diff[WIDTH+1];

   logic [2*WIDTH-1:0] prodMag;
   logic [2*WIDTH-1:0] prodRes;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   remd;

   assign prodMag = {accHi[WIDTH-1:0], accLo};
   assign prodRes = qSign ? -prodMag : prodMag;
   assign quo     = qSign ? -accLo : accLo;
   assign remd    = rSign ? -accHi[WIDTH-1:0] : accHi[WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         count    <= '0;
         opDiv    <= 1'b0;
         qSign    <= 1'b0;
         rSign    <= 1'b0;
         zeroFlag <= 1'b0;
         accHi    <= '0;
         accLo    <= '0;
         opB      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         done <= 1'b0;
         if (abort && state != IDLE) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (accept) begin
                     opDiv    <= divOp;
                     qSign    <= aNeg ^ bNeg;
                     rSign    <= aNeg;
                     zeroFlag <= divOp && bZero;
                     div_zero <= 1'b0;
                     busy     <= 1'b1;
                     count    <= '0;
                     accHi    <= '0;
                     accLo    <= aMag;
                     opB      <= bMag;
                     state    <= (divOp && bZero) ? FIX : CALC;
                  end
               end
               CALC: begin
                  if (opDiv) begin
                     accHi <= fits ? diff[WIDTH:0] : shifted;
                     accLo <= {accLo[WIDTH-2:0], fits};
                  end else begin
                     accHi <= {1'b0, mulSum[WIDTH:1]};
                     accLo <= {mulSum[0], accLo[WIDTH-1:1]};
                  end
                  count <= count + 1'b1;
                  if (count == LASTCNT) state <= FIX;
               end
               FIX: begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  div_zero <= zeroFlag;
                  if (!zeroFlag) begin
                     if (opDiv) begin
                        hi <= remd;
                        lo <= quo;
                     end else begin
                        hi <= prodRes[2*WIDTH-1:WIDTH];
                        lo <= prodRes[WIDTH-1:0];
                     end
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/mult_div_seq.md
# mult_div_seq

Parametrised sequential multiply/divide unit for the multicycle CPU datapath, replacing the fixed 32-bit separate multiplier and divider with one shared iterative engine. It computes signed or unsigned products into a 2·WIDTH Hi:Lo pair, and signed or unsigned quotient/remainder, one bit per cycle. It adds a start/busy/done handshake, a divide-by-zero flag and an abort input, so the control FSM can sequence MULT/MULTU/DIV/DIVU and write the HI/LO registers on `done`.

## Interface
- WIDTH, 32, operand width; hi/lo each WIDTH bits; WIDTH ≥ 4.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; overrides all other inputs.
- start  in  1  request; accepted only in IDLE with abort=0.
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU; sampled with start.
- a  in  WIDTH  multiplicand / dividend; sampled with start.
- b  in  WIDTH  multiplier / divisor; sampled with start.
- abort  in  1  cancels the operation in flight; has priority over start.
- busy  out  1  high while an accepted operation is in progress.
- done  out  1  one-cycle pulse; hi/lo/div_zero valid in that cycle.
- div_zero  out  1  high with done when a divide had b==0; cleared on next accepted start.
- hi  out  WIDTH  product[2W-1:W] or remainder; held until the next done.
- lo  out  WIDTH  product[W-1:0] or quotient; held until the next done.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, start=1, abort=0:
  - latch op; for signed ops, latch |a| and |b| plus the sign bits (rsign = sign(a); qsign = sign(a)^sign(b)); clear div_zero.
  - If the op is a divide and b==0, go to FIX with the zero flag set. Otherwise go to CALC with the count at 0.
- CALC, multiply: shift-add on magnitudes into a 2W product register, one multiplier bit per cycle.
- CALC, divide: restoring division with a W+1-bit partial remainder and one quotient bit per cycle.
- CALC lasts exactly WIDTH cycles, then goes to FIX.
- FIX:
  - Apply signs (product negated if qsign; quotient negated if qsign; remainder negated if rsign). All results are truncated mod 2^W per half.
  - Register hi/lo and pulse done. Go to IDLE.
  - Zero-divide case: hi/lo keep their previous values and div_zero=1.
- Signed divide truncates toward zero; the remainder takes the dividend's sign.
- Most-negative / -1 wraps: lo=most-negative, hi=0. No flag is raised.
- start while busy: ignored; there is no queueing.
- abort while busy: next state IDLE. No done; hi/lo/div_zero unchanged.
- abort in IDLE: no effect, and it blocks a simultaneous start.
- reset: state IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0. Reset mid-operation discards the operation.

## Timing
- Start sampled at the end of cycle T. busy is high during cycles T+1 … T+WIDTH+1.
- done is high in cycle T+WIDTH+2, and busy is low in that same cycle. Latency is WIDTH+2 (34 cycles for WIDTH=32).
- Divide by zero: busy is high in T+1 only; done and div_zero are high in T+2.
- A start asserted in the done cycle is accepted, giving back-to-back throughput of one operation per WIDTH+2 cycles.
- Abort sampled in cycle U: busy is low in U+1.
- hi/lo change only at the edge that raises done (or on reset). All outputs are registered.

## Structure
- Shared package mult_div_pkg holds:
  - the op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - the state enum: IDLE, CALC, FIX.
- The control FSM imports the same op constants.
- Single module; no sub-module is needed.
- Sign/magnitude conversion and the iteration datapath are inline.
- The iteration counter is $clog2(WIDTH)+1 bits.

## Test plan
All values use WIDTH=32.
- MULT a=0xFFFFFFFD (-3), b=7 → done at T+34, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high T+1…T+33.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=-7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 → lo=3, hi=1.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0, div_zero=0.
- DIVU a=5, b=0 after a prior result hi=1, lo=3 → done and div_zero at T+2; hi=1, lo=3 unchanged.
- Abort and handshake sequence:
  - MULT started, abort at T+10 → busy low T+11, no done, hi/lo unchanged.
  - start pulsed at T+5 of a new operation → ignored.
  - new start in the done cycle → accepted, second done 34 cycles later.
  - reset mid-CALC → all outputs 0 next cycle.
